phase_sequencer: RTL and testbench

Beat-phase controller for the multi-cycle RISC core. Replaces the free-running phase counter with a sequenced one that supports run, halt and single-step. Generates one-hot phase strobes T[0..PHASES-1] that drive the fetch, decode, execute and writeback control decode. Honours a datapath stall, stops cleanly at instruction boundaries, and counts retired instructions.

---
 rtl/phase_sequencer.sv | 101 ++++++++++
 tb/tb_phase_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Beat-phase sequencer: one-hot phase strobes with run, halt and single-step.
// Counts retired instructions; stall freezes the current phase.
module phase_sequencer #(
  parameter int PHASES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       step,
  input  logic                       stall,
  input  logic                       halt_req,
  output logic [PHASES-1:0]          T,
  output logic [$clog2(PHASES)-1:0]  phase,
  output logic                       busy,
  output logic                       instr_done,
  output logic [CNT_W-1:0]           instr_cnt
);

  localparam int PW = $clog2(PHASES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP
  } state_t;

  state_t            state, state_d;
  logic [PHASES-1:0] t_d;
  logic [PW-1:0]     phase_d;
  logic              done_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              last;

  assign last = T[PHASES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      T          <= '0;
      phase      <= '0;
      busy       <= 1'b0;
      instr_done <= 1'b0;
      instr_cnt  <= '0;
    end else begin
      state      <= state_d;
      T          <= t_d;
      phase      <= phase_d;
      busy       <= |t_d;
      instr_done <= done_d;
      instr_cnt  <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    t_d     = T;
    phase_d = phase;
    done_d  = 1'b0;
    cnt_d   = instr_cnt;
    unique case (state)
      IDLE: begin
        t_d     = '0;
        phase_d = '0;
        if (start) begin
          state_d = RUN;
          t_d     = PHASES'(1);
        end else if (step) begin
          state_d = STEP;
          t_d     = PHASES'(1);
        end
      end
      RUN, STEP: begin
        if (!stall) begin
          if (last) begin
            done_d = 1'b1;
            cnt_d  = instr_cnt + CNT_W'(1);
            // halt is only honoured here, at the boundary
            if (state == RUN && !halt_req) begin
              t_d     = PHASES'(1);
              phase_d = '0;
            end else begin
              state_d = IDLE;
              t_d     = '0;
              phase_d = '0;
            end
          end else begin
            t_d     = T << 1;
            phase_d = phase + PW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
        phase_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized self-checking bench for phase_sequencer against a
// phase-index/mode reference model; a second instance checks CNT_W=2 wrap.
module tb_phase_sequencer;

  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic step = 1'b0;
  logic stall = 1'b0;
  logic halt_req = 1'b0;

  logic [3:0]  t, t_w;
  logic [1:0]  phase, phase_w;
  logic        busy, busy_w, done, done_w;
  logic [15:0] cnt;
  logic [1:0]  cnt_w;

  int nvec = 0;
  int nerr = 0;

  // model: mode 0=idle 1=run 2=step, mph=active phase index
  int          mmode, mph, mdone;
  int unsigned mcnt;

  phase_sequencer #(.PHASES(P), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .stall(stall), .halt_req(halt_req), .T(t), .phase(phase),
    .busy(busy), .instr_done(done), .instr_cnt(cnt)
  );

  phase_sequencer #(.PHASES(P), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .stall(stall), .halt_req(halt_req), .T(t_w), .phase(phase_w),
    .busy(busy_w), .instr_done(done_w), .instr_cnt(cnt_w)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] expv();
    logic [3:0] et;
    logic [1:0] ep;
    logic       eb;
    et = (mmode != 0) ? 4'(1 << mph) : 4'b0;
    ep = (mmode != 0) ? 2'(mph) : 2'd0;
    eb = (mmode != 0);
    return {et, ep, eb, 1'(mdone), 16'(mcnt),
            et, ep, eb, 1'(mdone), 2'(mcnt)};
  endfunction

  function automatic logic [33:0] obsv();
    return {t, phase, busy, done, cnt,
            t_w, phase_w, busy_w, done_w, cnt_w};
  endfunction

  task automatic mreset();
    mmode = 0;
    mph   = 0;
    mdone = 0;
    mcnt  = 0;
  endtask

  // advance one clock, update the model from the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      mreset();
    end else if (mmode == 0) begin
      mdone = 0;
      if (start) begin
        mmode = 1;
        mph   = 0;
      end else if (step) begin
        mmode = 2;
        mph   = 0;
      end
    end else begin
      mdone = 0;
      if (!stall) begin
        if (mph == P - 1) begin
          mdone = 1;
          mcnt  = mcnt + 1;
          mph   = 0;
          if (mmode == 2 || halt_req) mmode = 0;
        end else begin
          mph = mph + 1;
        end
      end
    end
    #1;
  endtask

  task automatic clear_in();
    start = 0; step = 0; stall = 0; halt_req = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    repeat (2) tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    if (obsv() !== expv()) begin
      nerr++;
      $display("FAIL reset_held got=%h want=%h", obsv(), expv());
    end
    nvec++;
    for (int i = 0; i < 5; i++) begin
      stall    = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      tick();
      if (obsv() !== expv() || t !== 4'b0000 || cnt !== 16'd0) begin
        nerr++;
        $display("FAIL reset_idle%0d got=%h want=%h", i, obsv(), expv());
      end
      nvec++;
    end
    clear_in();
  endtask

  task automatic test_run();
    logic [15:0] c0;
    do_reset();
    c0 = cnt;
    start = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      start = 0;
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL run_cyc%0d got=%h want=%h", i, obsv(), expv());
      end
      nvec++;
      if (i == 9) begin
        if (cnt - c0 !== 16'd2 || done !== 1'b1) begin
          nerr++;
          $display("FAIL run_cnt9 got=%0d/%b want=2/1", cnt - c0, done);
        end
        nvec++;
      end
    end
  endtask

  task automatic test_stall();
    int scnt;
    do_reset();
    start = 1;
    tick();
    start = 0;
    scnt = 0;
    for (int i = 0; i < 14; i++) begin
      stall = (mph == 2 && mmode != 0 && scnt < 3);
      if (stall) scnt++;
      tick();
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL stall_cyc%0d got=%h want=%h", i, obsv(), expv());
      end
      nvec++;
    end
    stall = 0;
  endtask

  task automatic test_halt();
    logic [15:0] c0;
    int n;
    do_reset();
    start = 1;
    tick();
    start = 0;
    tick();
    halt_req = 1;
    c0 = cnt;
    n = 0;
    while (mmode != 0 && n < 12) begin
      tick();
      n++;
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL halt_cyc%0d got=%h want=%h", n, obsv(), expv());
      end
      nvec++;
    end
    if (n != 3 || t !== 4'b0 || busy !== 1'b0 || done !== 1'b1
        || cnt !== c0 + 16'd1) begin
      nerr++;
      $display("FAIL halt_end got=n%0d t%b b%b d%b c%0d want=n3 t0000 b0 d1 c%0d",
               n, t, busy, done, cnt, c0 + 16'd1);
    end
    nvec++;
    halt_req = 0;
    repeat (2) tick();
    start = 1;
    tick();
    start = 0;
    if (obsv() !== expv() || t !== 4'b0001) begin
      nerr++;
      $display("FAIL halt_resume got=%h want=%h", obsv(), expv());
    end
    nvec++;
  endtask

  task automatic test_step();
    int ndone;
    do_reset();
    step = 1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      step = 0;
      start = (i == 2);
      if (done) ndone++;
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL step_cyc%0d got=%h want=%h", i, obsv(), expv());
      end
      nvec++;
    end
    if (ndone != 1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL step_once got=%0d/%b want=1/0", ndone, busy);
    end
    nvec++;
    start = 1;
    step = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 0;
      step = 0;
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL startstep_cyc%0d got=%h want=%h", i, obsv(), expv());
      end
      nvec++;
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    #2;
    reset = 1;
    #1;
    if (t !== 4'b0 || cnt !== 16'd0 || busy !== 1'b0 || t_w !== 4'b0) begin
      nerr++;
      $display("FAIL midop_async got=t%b c%0d b%b want=t0000 c0 b0",
               t, cnt, busy);
    end
    nvec++;
    tick();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obsv() !== expv() || done !== 1'b0) begin
        nerr++;
        $display("FAIL midop_after%0d got=%h want=%h", i, obsv(), expv());
      end
      nvec++;
    end
  endtask

  task automatic test_wrap();
    logic [1:0] seq [5];
    int k;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    start = 1;
    k = 0;
    for (int i = 0; i < 21; i++) begin
      tick();
      start = 0;
      halt_req = (i >= 16);
      if (done_w && k < 5) begin
        if (cnt_w !== seq[k]) begin
          nerr++;
          $display("FAIL wrap%0d got=%0d want=%0d", k, cnt_w, seq[k]);
        end
        nvec++;
        k++;
      end
    end
    if (k != 5 || obsv() !== expv()) begin
      nerr++;
      $display("FAIL wrap_end got=k%0d %h want=k5 %h", k, obsv(), expv());
    end
    nvec++;
    halt_req = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      start    = ($urandom_range(0, 9) == 0);
      step     = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 6) == 0);
      tick();
      if (obsv() !== expv()) begin
        nerr++;
        $display("FAIL rand_cyc%0d got=%h want=%h", i, obsv(), expv());
      end
      nvec++;
    end
    clear_in();
  endtask

  initial begin
    mreset();
    test_reset();
    test_run();
    test_stall();
    test_halt();
    test_step();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
